// File: rtl/fetch_block_scheduler_if.sv
// Scheduler <-> FetchSP / compute / control handshake bundle.
// master: scheduler side; slave: environment (FetchSP, compute, host).
interface fetch_block_scheduler_if;
  logic       go;
  logic       fetch_start;
  logic       fetch_done;
  logic [4:0] Rb;
  logic [4:0] Cb;
  logic       Y_finished;
  logic       U_finished;
  logic       fetch_bank;
  logic       comp_start;
  logic       comp_bank;
  logic [1:0] comp_plane;
  logic       comp_done;
  logic       busy;
  logic       frame_done;
  logic       err;

  modport master (
    input  go, fetch_done, comp_done,
    output fetch_start, Rb, Cb,
    output Y_finished, U_finished,
    output fetch_bank, comp_start,
    output comp_bank, comp_plane,
    output busy, frame_done, err
  );

  modport slave (
    output go, fetch_done, comp_done,
    input  fetch_start, Rb, Cb,
    input  Y_finished, U_finished,
    input  fetch_bank, comp_start,
    input  comp_bank, comp_plane,
    input  busy, frame_done, err
  );
endinterface

// File: rtl/fetch_block_scheduler.sv
// Frame walker for FetchSP (Y, U, V raster) with ping-pong bank handoff.
// Ports: Clock, Resetn (async low), bus (master: go/fetch/compute/status).
module fetch_block_scheduler #(
  parameter int Y_BCOLS = 12,
  parameter int Y_BROWS = 9,
  parameter int C_BCOLS = 12,
  parameter int C_BROWS = 18
) (
  input  logic Clock,
  input  logic Resetn,
  fetch_block_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_FETCH, DRAIN
  } state_t;

  typedef enum logic [1:0] {
    FREE, FILLING, FULL, COMPUTING
  } bank_t;

  localparam logic [1:0] PY = 2'd0;
  localparam logic [1:0] PU = 2'd1;
  localparam logic [1:0] PV = 2'd2;

  localparam logic [4:0] Y_LC = 5'(Y_BCOLS - 1);
  localparam logic [4:0] Y_LR = 5'(Y_BROWS - 1);
  localparam logic [4:0] C_LC = 5'(C_BCOLS - 1);
  localparam logic [4:0] C_LR = 5'(C_BROWS - 1);

  state_t     state, state_nx;
  bank_t      bank [2];
  logic [1:0] tag  [2];

  logic [4:0] rb, cb, rb_nx, cb_nx;
  logic [1:0] plane, plane_nx;
  logic       y_fin, u_fin;
  logic       fetch_bank, comp_bank;
  logic [1:0] comp_plane;
  logic       fetch_start, comp_start;
  logic       frame_done, busy, err;

  logic start_frame, do_issue, do_fetch;
  logic do_disp, do_cdone, do_fin;
  logic err_set, all_free, any_comp;
  logic last_col, last_row, last_blk;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.go) state_nx = ISSUE;
      ISSUE:
        if (bank[fetch_bank] == FREE)
          state_nx = WAIT_FETCH;
      WAIT_FETCH:
        if (bus.fetch_done)
          state_nx = last_blk ? DRAIN : ISSUE;
      DRAIN:
        if (all_free) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    last_col = 1'b0;
    last_row = 1'b0;
    unique case (1'b1)
      (plane == PY): begin
        last_col = (cb == Y_LC);
        last_row = (rb == Y_LR);
      end
      default: begin
        last_col = (cb == C_LC);
        last_row = (rb == C_LR);
      end
    endcase
    last_blk = (plane == PV) && last_col
            && last_row;

    cb_nx    = cb + 5'd1;
    rb_nx    = rb;
    plane_nx = plane;
    if (last_col) begin
      cb_nx = 5'd0;
      rb_nx = rb + 5'd1;
      if (last_row) begin
        rb_nx    = 5'd0;
        plane_nx = last_blk ? PY : plane + 2'd1;
      end
    end

    all_free = (bank[0] == FREE)
            && (bank[1] == FREE);
    any_comp = (bank[0] == COMPUTING)
            || (bank[1] == COMPUTING);

    start_frame = (state == IDLE) && bus.go;
    do_issue = (state == ISSUE)
            && (bank[fetch_bank] == FREE);
    do_fetch = (state == WAIT_FETCH)
            && bus.fetch_done;
    // Compute is in-order: only comp_bank can ever be COMPUTING.
    do_disp  = busy && !any_comp
            && (bank[comp_bank] == FULL);
    do_cdone = bus.comp_done
            && (bank[comp_bank] == COMPUTING);
    do_fin   = (state == DRAIN) && all_free;
    err_set  = (bus.comp_done && !do_cdone)
            || (bus.fetch_done
                && (state != WAIT_FETCH));
  end

  // Per cycle, issue/fetch/dispatch/release each touch a bank in a
  // distinct source state, so no two updates ever hit the same bank.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rb          <= '0;
      cb          <= '0;
      plane       <= PY;
      y_fin       <= 1'b0;
      u_fin       <= 1'b0;
      fetch_bank  <= 1'b0;
      comp_bank   <= 1'b0;
      comp_plane  <= '0;
      fetch_start <= 1'b0;
      comp_start  <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        bank[i] <= FREE;
        tag[i]  <= PY;
      end
    end else begin
      fetch_start <= do_issue;
      comp_start  <= do_disp;
      frame_done  <= do_fin;
      if (err_set) err <= 1'b1;
      if (start_frame) begin
        busy       <= 1'b1;
        err        <= 1'b0;
        rb         <= '0;
        cb         <= '0;
        plane      <= PY;
        y_fin      <= 1'b0;
        u_fin      <= 1'b0;
        fetch_bank <= 1'b0;
        comp_bank  <= 1'b0;
        for (int i = 0; i < 2; i++)
          bank[i] <= FREE;
      end else begin
        if (do_issue)
          bank[fetch_bank] <= FILLING;
        if (do_fetch) begin
          bank[fetch_bank] <= FULL;
          tag[fetch_bank]  <= plane;
          fetch_bank       <= ~fetch_bank;
          cb               <= cb_nx;
          rb               <= rb_nx;
          plane            <= plane_nx;
          y_fin            <= (plane_nx != PY);
          u_fin            <= (plane_nx == PV);
        end
        if (do_disp) begin
          bank[comp_bank] <= COMPUTING;
          comp_plane      <= tag[comp_bank];
        end
        if (do_cdone) begin
          bank[comp_bank] <= FREE;
          comp_bank       <= ~comp_bank;
        end
        if (do_fin) busy <= 1'b0;
      end
    end
  end

  assign bus.fetch_start = fetch_start;
  assign bus.Rb          = rb;
  assign bus.Cb          = cb;
  assign bus.Y_finished  = y_fin;
  assign bus.U_finished  = u_fin;
  assign bus.fetch_bank  = fetch_bank;
  assign bus.comp_start  = comp_start;
  assign bus.comp_bank   = comp_bank;
  assign bus.comp_plane  = comp_plane;
  assign bus.busy        = busy;
  assign bus.frame_done  = frame_done;
  assign bus.err         = err;

endmodule

// File: tb/tb_fetch_block_scheduler.sv
// Directed bench for fetch_block_scheduler: full frames, stalls,
// simultaneous done pulses, mid-frame reset, error flag behaviour.
module tb_fetch_block_scheduler;

  logic Clock;
  logic Resetn;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  fetch_block_scheduler_if bus ();

  fetch_block_scheduler dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int f_lat, c_lat;
  bit c_en;
  int fcd, ccd;
  bit fd_force, cd_force;
  int f_cnt, c_cnt, d_cnt;
  bit outst;
  logic [11:0] held;
  int stab_err;

  logic [12:0] f_rec [540];
  logic [2:0]  c_rec [540];

  logic [20:0] outs;
  assign outs = {bus.fetch_start, bus.Rb, bus.Cb,
                 bus.Y_finished, bus.U_finished,
                 bus.fetch_bank, bus.comp_start,
                 bus.comp_bank, bus.comp_plane,
                 bus.busy, bus.frame_done, bus.err};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    if (bus.fetch_done) outst = 1'b0;
    if (outst && {bus.Rb, bus.Cb, bus.Y_finished,
                  bus.U_finished} != held)
      stab_err++;
    bus.go         = 1'b0;
    bus.fetch_done = 1'b0;
    bus.comp_done  = 1'b0;
    if (fcd > 0) begin
      fcd--;
      if (fcd == 0) bus.fetch_done = 1'b1;
    end
    if (ccd > 0) begin
      ccd--;
      if (ccd == 0) bus.comp_done = 1'b1;
    end
    if (fd_force) begin
      bus.fetch_done = 1'b1;
      fd_force = 1'b0;
    end
    if (cd_force) begin
      bus.comp_done = 1'b1;
      cd_force = 1'b0;
    end
    if (bus.fetch_start) begin
      held = {bus.Rb, bus.Cb, bus.Y_finished,
              bus.U_finished};
      if (f_cnt < 540)
        f_rec[f_cnt] = {held, bus.fetch_bank};
      f_cnt++;
      fcd   = f_lat;
      outst = 1'b1;
    end
    if (bus.comp_start) begin
      if (c_cnt < 540)
        c_rec[c_cnt] = {bus.comp_plane, bus.comp_bank};
      c_cnt++;
      if (c_en) ccd = c_lat;
    end
    if (bus.frame_done) d_cnt++;
  endtask

  task automatic clr_counts();
    f_cnt = 0;
    c_cnt = 0;
    d_cnt = 0;
    stab_err = 0;
  endtask

  task automatic reset_dut();
    Resetn         = 1'b0;
    fcd            = 0;
    ccd            = 0;
    fd_force       = 1'b0;
    cd_force       = 1'b0;
    outst          = 1'b0;
    bus.go         = 1'b0;
    bus.fetch_done = 1'b0;
    bus.comp_done  = 1'b0;
    tick();
    tick();
    chk("rst_outs", outs, 0);
    Resetn = 1'b1;
    tick();
    chk("rst_idle", outs, 0);
  endtask

  task automatic run_frame(input int fl, input int cl);
    int cyc;
    int p, idx;
    logic [4:0] erb, ecb;
    logic [12:0] ef;
    logic [2:0] ec;
    f_lat = fl;
    c_lat = cl;
    c_en  = 1'b1;
    clr_counts();
    bus.go = 1'b1;
    tick();
    cyc = 0;
    while (d_cnt == 0 && cyc < 20000) begin
      if (cyc == 300) bus.go = 1'b1;
      tick();
      cyc++;
    end
    chk("frame_timeout", d_cnt != 0, 1);
    repeat (20) tick();
    chk("n_fetch", f_cnt, 540);
    chk("n_comp", c_cnt, 540);
    chk("n_done", d_cnt, 1);
    chk("idle_after",
        {bus.busy, bus.err, bus.fetch_bank,
         bus.comp_bank}, 0);
    chk("stable", stab_err, 0);
    chk("f0",   f_rec[0][12:1],   {5'd0,  5'd0,  2'b00});
    chk("f12",  f_rec[12][12:1],  {5'd1,  5'd0,  2'b00});
    chk("f107", f_rec[107][12:1], {5'd8,  5'd11, 2'b00});
    chk("f108", f_rec[108][12:1], {5'd0,  5'd0,  2'b10});
    chk("f323", f_rec[323][12:1], {5'd17, 5'd11, 2'b10});
    chk("f324", f_rec[324][12:1], {5'd0,  5'd0,  2'b11});
    chk("f539", f_rec[539][12:1], {5'd17, 5'd11, 2'b11});
    for (int n = 0; n < 540; n++) begin
      p   = (n < 108) ? 0 : (n < 324) ? 1 : 2;
      idx = n - ((p == 0) ? 0 : (p == 1) ? 108 : 324);
      erb = 5'(idx / 12);
      ecb = 5'(idx % 12);
      ef  = {erb, ecb, p != 0, p == 2, n[0]};
      ec  = {2'(p), n[0]};
      chk("fseq", f_rec[n], ef);
      chk("cseq", c_rec[n], ec);
    end
  endtask

  initial begin
    int cyc;
    f_lat = 2;
    c_lat = 3;
    c_en  = 1'b1;
    clr_counts();
    reset_dut();

    run_frame(2, 3);
    run_frame(3, 1);

    // compute never completes: ping-pong fills, then stalls
    reset_dut();
    clr_counts();
    f_lat = 2;
    c_en  = 1'b0;
    bus.go = 1'b1;
    tick();
    repeat (100) tick();
    chk("stall_f", f_cnt, 2);
    chk("stall_c", c_cnt, 1);
    chk("stall_busy", bus.busy, 1);
    cd_force = 1'b1;
    repeat (50) tick();
    chk("rel1_f", f_cnt, 3);
    chk("rel1_c", c_cnt, 2);
    f_lat = 0;
    cd_force = 1'b1;
    repeat (20) tick();
    chk("rel2_f", f_cnt, 4);
    chk("rel2_c", c_cnt, 3);
    fd_force = 1'b1;
    cd_force = 1'b1;
    repeat (20) tick();
    chk("sim_f", f_cnt, 5);
    chk("sim_c", c_cnt, 4);
    chk("sim_err", bus.err, 0);
    chk("sim_f4", f_rec[4], {5'd0, 5'd4, 2'b00, 1'b0});
    chk("sim_c3", c_rec[3], 3'b001);

    // reset in the middle of a frame, then restart
    reset_dut();
    clr_counts();
    f_lat = 2;
    c_lat = 3;
    c_en  = 1'b1;
    bus.go = 1'b1;
    tick();
    cyc = 0;
    while (f_cnt < 51 && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("mid_reach", f_cnt, 51);
    reset_dut();
    clr_counts();
    bus.go = 1'b1;
    tick();
    cyc = 0;
    while (f_cnt < 1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("restart_f0", f_rec[0], 13'd0);

    // spurious done pulses while idle
    reset_dut();
    cd_force = 1'b1;
    tick();
    tick();
    chk("err_cdone", bus.err, 1);
    repeat (5) tick();
    chk("err_held", bus.err, 1);
    bus.go = 1'b1;
    tick();
    chk("err_clr", {bus.busy, bus.err}, 2'b10);
    reset_dut();
    fd_force = 1'b1;
    tick();
    tick();
    chk("err_fdone", bus.err, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
